qdma_stream_model: RTL

QDMA_STREAM_MODEL -- requirements
Module: qdma_stream_model

---
 rtl/qdma_stream_model_if.sv | 35 +++
 rtl/qdma_stream_model.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/qdma_stream_model_if.sv
// AXIS channel bundles for the QDMA stream model: H2C (with tuser fields) and C2H (with ctrl_len/mty).
// Pure wiring, no latency; tready is the only signal driven by the sink side.
interface qdma_h2c_if #(
  parameter int DATA_W = 512,
  parameter int QID_W  = 11
);
  localparam int MTY_W = $clog2(DATA_W / 8);

  logic [DATA_W-1:0] tdata;
  logic [QID_W-1:0]  tuser_qid;
  logic [MTY_W-1:0]  tuser_mty;
  logic [31:0]       tuser_mdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (output tdata, tuser_qid, tuser_mty, tuser_mdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tuser_qid, tuser_mty, tuser_mdata, tvalid, tlast, output tready);
endinterface

interface qdma_c2h_if #(
  parameter int DATA_W = 512
);
  localparam int MTY_W = $clog2(DATA_W / 8);

  logic [DATA_W-1:0] tdata;
  logic [15:0]       ctrl_len;
  logic [MTY_W-1:0]  mty;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (output tdata, ctrl_len, mty, tvalid, tlast, input tready);
  modport slave  (input tdata, ctrl_len, mty, tvalid, tlast, output tready);
endinterface

// File: rtl/qdma_stream_model.sv
// H2C burst generator (first beat the cycle after start, back-to-back, holds on tready=0) plus
// C2H sink with packet/byte/length-error statistics; C2H tready is high whenever out of reset.
module qdma_stream_model #(
  parameter int DATA_W = 512,
  parameter int NUM_Q  = 4,
  parameter int QID_W  = 11
) (
  input  logic              axi_aclk,
  input  logic              axi_aresetn,
  input  logic              start,
  input  logic [15:0]       pkt_len,
  input  logic [31:0]       pkt_count,
  input  logic [QID_W-1:0]  qid_base,
  output logic              busy,
  output logic              done,
  qdma_h2c_if.master        m_axis_h2c,
  qdma_c2h_if.slave         s_axis_c2h,
  input  logic              clr_cnt,
  output logic [31:0]       c2h_pkt_cnt,
  output logic [31:0]       c2h_byte_cnt,
  output logic [31:0]       c2h_err_cnt
);
  localparam int BYTES = DATA_W / 8;
  localparam int MTY_W = $clog2(BYTES);
  localparam int QO_W  = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  state_t state_q, state_d;

  logic [15:0]      len_q;
  logic [31:0]      cnt_q;
  logic [QID_W-1:0] qbase_q;
  logic [16:0]      nb_q;
  logic [16:0]      beat_q;
  logic [31:0]      pkt_q;
  logic [QO_W-1:0]  qoff_q;

  logic        go;
  logic [16:0] nb_in;
  logic        send;
  logic        accept;
  logic        last_beat;
  logic        last_pkt;

  assign go        = start && (pkt_len != 16'd0) && (pkt_count != 32'd0);
  assign nb_in     = ({1'b0, pkt_len} + 17'(BYTES - 1)) >> MTY_W;
  assign send      = (state_q == SEND);
  assign accept    = send && m_axis_h2c.tready;
  assign last_beat = (beat_q == nb_q - 17'd1);
  assign last_pkt  = (pkt_q == cnt_q - 32'd1);

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) state_q <= IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = go ? SEND : DONE;
      SEND:    if (accept && last_beat && last_pkt) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Burst parameters are captured only on the IDLE->SEND edge so input churn mid-burst is harmless.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      len_q   <= '0;
      cnt_q   <= '0;
      qbase_q <= '0;
      nb_q    <= '0;
      beat_q  <= '0;
      pkt_q   <= '0;
      qoff_q  <= '0;
    end else if (state_q == IDLE && go) begin
      len_q   <= pkt_len;
      cnt_q   <= pkt_count;
      qbase_q <= qid_base;
      nb_q    <= nb_in;
      beat_q  <= '0;
      pkt_q   <= '0;
      qoff_q  <= '0;
    end else if (accept) begin
      if (last_beat) begin
        beat_q <= '0;
        pkt_q  <= pkt_q + 32'd1;
        qoff_q <= (qoff_q == QO_W'(NUM_Q - 1)) ? '0 : qoff_q + QO_W'(1);
      end else begin
        beat_q <= beat_q + 17'd1;
      end
    end
  end

  assign busy = send;
  assign done = (state_q == DONE);

  // Outputs derive from registered state only, so they are stable across a stall.
  always_comb begin
    m_axis_h2c.tvalid      = 1'b0;
    m_axis_h2c.tlast       = 1'b0;
    m_axis_h2c.tdata       = '0;
    m_axis_h2c.tuser_qid   = '0;
    m_axis_h2c.tuser_mty   = '0;
    m_axis_h2c.tuser_mdata = '0;
    if (send) begin
      m_axis_h2c.tvalid      = 1'b1;
      m_axis_h2c.tlast       = last_beat;
      m_axis_h2c.tdata       = {BYTES{beat_q[7:0]}};
      m_axis_h2c.tuser_qid   = qbase_q + QID_W'(qoff_q);
      m_axis_h2c.tuser_mdata = {16'd0, len_q};
      if (last_beat) m_axis_h2c.tuser_mty = {MTY_W{1'b0}} - len_q[MTY_W-1:0];
    end
  end

  // C2H sink
  logic [31:0] acc_q;
  logic [31:0] beat_bytes;
  logic [31:0] acc_sum;
  logic        c2h_acc;

  assign s_axis_c2h.tready = axi_aresetn;
  assign c2h_acc    = s_axis_c2h.tvalid && s_axis_c2h.tready;
  assign beat_bytes = s_axis_c2h.tlast ? (32'(BYTES) - 32'(s_axis_c2h.mty)) : 32'(BYTES);
  assign acc_sum    = acc_q + beat_bytes;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      acc_q        <= '0;
      c2h_pkt_cnt  <= '0;
      c2h_byte_cnt <= '0;
      c2h_err_cnt  <= '0;
    end else if (clr_cnt) begin
      acc_q        <= '0;
      c2h_pkt_cnt  <= '0;
      c2h_byte_cnt <= '0;
      c2h_err_cnt  <= '0;
    end else if (c2h_acc) begin
      c2h_byte_cnt <= c2h_byte_cnt + beat_bytes;
      if (s_axis_c2h.tlast) begin
        c2h_pkt_cnt <= c2h_pkt_cnt + 32'd1;
        if (acc_sum != {16'd0, s_axis_c2h.ctrl_len}) c2h_err_cnt <= c2h_err_cnt + 32'd1;
        acc_q <= '0;
      end else begin
        acc_q <= acc_sum;
      end
    end
  end
endmodule
